mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store sequencer that drives the byte-addressed, little-endian data memory on behalf of the datapath.
- Accepts one request at a time through a valid/ready handshake and range-checks it.
- Aligned accesses are issued as a single memory transfer. Misaligned accesses are split into consecutive single-byte transfers, since the memory only supports aligned accesses.
- Assembles load bytes, applies sign or zero extension, and returns a one-cycle response.

Parameters:
- MEM_BYTES, 1024, memory size in bytes (power of two, >8); used for the bounds check.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_addr  in  64  byte address
- req_size  in  4  access size in bytes: 1, 2, 4 or 8
- req_signed  in  1  load result sign-extended when 1, zero-extended when 0
- req_wdata  in  64  store data; low req_size bytes used
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  load result (0 for stores and errors)
- resp_err  out  1  qualifies resp_valid; illegal size or out of bounds
- mem_address  out  64  to memory
- mem_write_enable  out  1  to memory
- mem_read_enable  out  1  to memory
- mem_write_data  out  64  to memory
- mem_xfer_size  out  4  to memory
- mem_read_data  in  64  from memory; combinational, valid in the same cycle as the read

Behaviour:
- Reset (async, high): state=IDLE; resp_valid=0; resp_rdata=0; resp_err=0; mem_write_enable=0; mem_read_enable=0; mem_address=0; mem_write_data=0; mem_xfer_size=8; byte counter=0; assembly register=0.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid=1, latch addr, size, write, signed and wdata; clear the assembly register.
  - If size is not in {1,2,4,8}, or addr+size > MEM_BYTES (computed 65 bits wide, no wrap), go to RESP with err=1 and issue no memory access.
  - Else if (addr & (size-1))==0, go to ALIGNED.
  - Else go to SPLIT with k=0.
- ALIGNED (one cycle):
  - mem_address=addr, mem_xfer_size=size, mem_write_data=wdata.
  - Exactly one of mem_write_enable / mem_read_enable is high, per write.
  - Loads capture the low size bytes of mem_read_data at the posedge; upper bytes are ignored.
  - Next state RESP.
- SPLIT (size cycles):
  - Cycle k: mem_address=addr+k, mem_xfer_size=1, mem_write_data[7:0]=wdata byte k, upper bits 0.
  - Loads capture mem_read_data[7:0] into assembly byte k.
  - k increments each cycle; after k=size-1, go to RESP.
- RESP (one cycle):
  - resp_valid=1, resp_err as determined in IDLE.
  - Loads: resp_rdata = assembled value extended from size*8 bits; sign-extend if signed=1, zero-extend otherwise. A size-8 load is passed through unchanged.
  - Stores and errors: resp_rdata=0.
  - req_ready=0. Next state IDLE.
- mem_* outputs hold their reset values in IDLE and RESP; both enables are never high together.
- Latency, counted in edges from the accepting edge to resp_valid high:
  - aligned: 2 edges;
  - misaligned: size+1 edges;
  - error: 1 edge.
- Throughput: the next request can be accepted the cycle after RESP.
- A request presented while req_ready=0 is not accepted; the requester must hold it.
- Reset mid-operation aborts with no response. Store bytes written before the reset edge remain in memory; no rollback.
- Misaligned access at the top of memory: the bounds check uses the full span, so addr=1020, size=8 returns an error.

Test Plan:
- Aligned store then load: store addr=0x10, size=8, wdata=0x8877665544332211. Then load addr=0x10, size=8 -> resp_rdata=0x8877665544332211, err=0, resp 2 edges after accept, mem_xfer_size=8 for 1 cycle.
- Sign/zero extension: store byte 0x80 at addr=0x20. Load size=1, signed=1 -> 0xFFFFFFFFFFFFFF80. Load size=1, signed=0 -> 0x0000000000000080. Load size=2 of 0x8001 with signed=1 -> 0xFFFFFFFFFFFF8001.
- Misaligned split: store addr=0x13, size=4, wdata=0xDEADBEEF -> 4 byte writes at 0x13..0x16 with data EF, BE, AD, DE. Then load addr=0x13, size=4, signed=0 -> 0x00000000DEADBEEF after 5 edges. An aligned size-8 load at 0x10 shows bytes 3..6 = EF, BE, AD, DE.
- Errors:
  - req_size=3 -> resp_err=1 next cycle, no enable asserted.
  - addr=1020, size=8 -> err=1.
  - addr=0xFFFFFFFFFFFFFFFC, size=8 -> err=1 (no wrap).
  - addr=1016, size=8 -> err=0.
- Handshake: hold req_valid high with back-to-back requests -> req_ready low during ALIGNED, SPLIT and RESP; each request is accepted exactly once; responses arrive in order.
- Reset mid-split: assert reset during cycle k=1 of an 8-byte misaligned store -> enables drop immediately, no resp_valid, state IDLE, req_ready=1 after reset is released.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer that splits misaligned accesses into byte transfers
module mem_access_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ALIGNED, SPLIT, RESP} state_t;
  state_t      state, state_nx;
  logic [63:0] addr, wdata, asm_data;
  logic [3:0]  size;
  logic        wr, sg, err;
  logic [2:0]  k;
  logic        size_ok, oob, bad, is_aligned, sign_bit, busy;
  logic [63:0] size_mask, ext_data;
  // request decode: legal size, full-span bounds check without wrap, natural alignment
  always_comb begin
    size_ok    = req_size inside {4'd1, 4'd2, 4'd4, 4'd8};
    oob        = ({1'b0, req_addr} + 65'(req_size)) > 65'(MEM_BYTES);
    bad        = !size_ok || oob;
    is_aligned = (req_addr & (64'(req_size) - 64'd1)) == 64'd0;
  end
  // next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (bad ? RESP : is_aligned ? ALIGNED : SPLIT) : IDLE;
      ALIGNED: state_nx = RESP;
      SPLIT:   state_nx = (4'(k) == size - 4'd1) ? RESP : SPLIT;
      default: state_nx = IDLE;
    endcase
  end
  // load result shaping: keep the low size bytes and extend from the top one
  always_comb begin
    size_mask = (size == 4'd8) ? '1 : (64'd1 << {size, 3'b000}) - 64'd1;
    sign_bit  = (size == 4'd1) ? asm_data[7] : (size == 4'd2) ? asm_data[15] :
                (size == 4'd4) ? asm_data[31] : asm_data[63];
    ext_data  = (asm_data & size_mask) | ((sg && sign_bit) ? ~size_mask : 64'd0);
  end
  // state register, request latch and load byte assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      wdata    <= '0;
      size     <= '0;
      wr       <= 1'b0;
      sg       <= 1'b0;
      err      <= 1'b0;
      k        <= '0;
      asm_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid) begin
          addr     <= req_addr;
          wdata    <= req_wdata;
          size     <= req_size;
          wr       <= req_write;
          sg       <= req_signed;
          err      <= bad;
          k        <= '0;
          asm_data <= '0;
        end
        ALIGNED: if (!wr) asm_data <= mem_read_data & size_mask;
        SPLIT: begin
          if (!wr) asm_data[{k, 3'b000} +: 8] <= mem_read_data[7:0];
          k <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end
  // handshake, response and memory-side drive decoded from state
  always_comb begin
    busy             = (state == ALIGNED) || (state == SPLIT);
    req_ready        = state == IDLE;
    resp_valid       = state == RESP;
    resp_err         = (state == RESP) && err;
    resp_rdata       = ((state == RESP) && !err && !wr) ? ext_data : 64'd0;
    mem_write_enable = busy && wr;
    mem_read_enable  = busy && !wr;
    mem_address      = (state == ALIGNED) ? addr : (state == SPLIT) ? addr + 64'(k) : 64'd0;
    mem_xfer_size    = (state == ALIGNED) ? size : (state == SPLIT) ? 4'd1 : 4'd8;
    mem_write_data   = (state == ALIGNED) ? wdata :
                       (state == SPLIT) ? {56'd0, wdata[{k, 3'b000} +: 8]} : 64'd0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a byte-array memory with hand-computed results
module tb_mem_access_unit;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_write = 0, req_signed = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_size = 1;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;
  logic [7:0]  mem [1024];
  int          n_tests = 0, n_fail = 0;
  int          en_cycles, both_hi, nw, accepts;
  logic [3:0]  last_size;
  logic [63:0] wa [8];
  logic [7:0]  wd [8];
  logic [63:0] rd;
  logic        er;
  int          ed;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_write_data(mem_write_data), .mem_xfer_size(mem_xfer_size),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++) mem_read_data[i*8 +: 8] = mem[int'(mem_address[9:0] + 10'(i))];
  end

  always @(posedge clk)
    if (mem_write_enable)
      for (int i = 0; i < 8; i++)
        if (i < int'(mem_xfer_size)) mem[int'(mem_address[9:0] + 10'(i))] <= mem_write_data[i*8 +: 8];

  always @(negedge clk) begin
    if (req_valid && req_ready) accepts++;
    if (mem_write_enable && mem_read_enable) both_hi++;
    if (mem_write_enable || mem_read_enable) begin
      en_cycles++;
      last_size = mem_xfer_size;
      if (mem_write_enable && nw < 8) begin
        wa[nw] = mem_address;
        wd[nw] = mem_write_data[7:0];
        nw++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [63:0] a, input logic [3:0] s,
                        input logic sgn, input logic [63:0] d,
                        output logic [63:0] rdata, output logic err, output int edges);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    en_cycles = 0; both_hi = 0; nw = 0; last_size = 0;
    req_write = w; req_addr = a; req_size = s; req_signed = sgn; req_wdata = d;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    edges = 1;
    while (!resp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!resp_valid) check("resp_timeout", 64'(edges), 64'(0));
    rdata = resp_rdata;
    err = resp_err;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_xfer_size", 64'(mem_xfer_size), 64'(8));
    check("rst_enables", 64'({mem_write_enable, mem_read_enable}), 64'(0));
    check("rst_addr", mem_address, 64'd0);
    reset = 0;
    @(posedge clk); #1;

    do_req(1, 64'h10, 8, 0, 64'h8877665544332211, rd, er, ed);
    check("st8_err", 64'(er), 64'(0));
    check("st8_edges", 64'(ed), 64'(2));
    check("st8_rdata", rd, 64'd0);
    check("st8_en_cycles", 64'(en_cycles), 64'(1));
    do_req(0, 64'h10, 8, 0, 64'h0, rd, er, ed);
    check("ld8_rdata", rd, 64'h8877665544332211);
    check("ld8_edges", 64'(ed), 64'(2));
    check("ld8_xfer_size", 64'(last_size), 64'(8));
    check("ld8_en_cycles", 64'(en_cycles), 64'(1));

    do_req(1, 64'h20, 1, 0, 64'h80, rd, er, ed);
    do_req(0, 64'h20, 1, 1, 64'h0, rd, er, ed);
    check("ldb_signed", rd, 64'hFFFFFFFFFFFFFF80);
    do_req(0, 64'h20, 1, 0, 64'h0, rd, er, ed);
    check("ldb_unsigned", rd, 64'h0000000000000080);
    do_req(1, 64'h22, 2, 0, 64'h8001, rd, er, ed);
    do_req(0, 64'h22, 2, 1, 64'h0, rd, er, ed);
    check("ldh_signed", rd, 64'hFFFFFFFFFFFF8001);

    do_req(1, 64'h13, 4, 0, 64'hDEADBEEF, rd, er, ed);
    check("mst_edges", 64'(ed), 64'(5));
    check("mst_writes", 64'(nw), 64'(4));
    check("mst_addrs", {wa[0][15:0], wa[1][15:0], wa[2][15:0], wa[3][15:0]}, 64'h0013_0014_0015_0016);
    check("mst_bytes", 64'({wd[0], wd[1], wd[2], wd[3]}), 64'hEFBEADDE);
    check("mst_size", 64'(last_size), 64'(1));
    do_req(0, 64'h13, 4, 0, 64'h0, rd, er, ed);
    check("mld_rdata", rd, 64'h00000000DEADBEEF);
    check("mld_edges", 64'(ed), 64'(5));
    do_req(0, 64'h10, 8, 0, 64'h0, rd, er, ed);
    check("mld_overlay", rd, 64'h88DEADBEEF332211);

    do_req(0, 64'h40, 3, 0, 64'h0, rd, er, ed);
    check("size3_err", 64'(er), 64'(1));
    check("size3_edges", 64'(ed), 64'(1));
    check("size3_no_en", 64'(en_cycles), 64'(0));
    check("size3_rdata", rd, 64'd0);
    do_req(0, 64'd1020, 8, 0, 64'h0, rd, er, ed);
    check("top_span_err", 64'(er), 64'(1));
    do_req(1, 64'hFFFFFFFFFFFFFFFC, 8, 0, 64'h1, rd, er, ed);
    check("wrap_err", 64'(er), 64'(1));
    check("wrap_no_en", 64'(en_cycles), 64'(0));
    do_req(0, 64'd1016, 8, 0, 64'h0, rd, er, ed);
    check("last_word_err", 64'(er), 64'(0));
    check("both_enables", 64'(both_hi), 64'(0));

    @(posedge clk); #1;
    accepts = 0;
    req_write = 1; req_addr = 64'h40; req_size = 4; req_signed = 0; req_wdata = 64'h11223344;
    req_valid = 1;
    @(posedge clk); #1;
    req_write = 0; req_wdata = 0;
    check("b2b_ready_aligned", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    check("b2b_ready_resp", 64'(req_ready), 64'(0));
    check("b2b_resp1", {63'd0, resp_valid}, 64'd1);
    check("b2b_rdata1", resp_rdata, 64'd0);
    @(posedge clk); #1;
    check("b2b_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 0;
    check("b2b_no_resp", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    check("b2b_resp2", 64'(resp_valid), 64'(1));
    check("b2b_rdata2", resp_rdata, 64'h11223344);
    check("b2b_accepts", 64'(accepts), 64'(2));

    @(posedge clk); #1;
    req_write = 1; req_addr = 64'h31; req_size = 8; req_signed = 0; req_wdata = 64'h0807060504030201;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    check("rsplit_k1_addr", mem_address, 64'h32);
    reset = 1;
    #1;
    check("rsplit_en_drop", 64'({mem_write_enable, mem_read_enable}), 64'(0));
    check("rsplit_ready", 64'(req_ready), 64'(1));
    check("rsplit_resp", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    reset = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rsplit_no_resp", 64'(resp_valid), 64'(0));
    end
    check("rsplit_ready_after", 64'(req_ready), 64'(1));
    check("rsplit_byte0_kept", 64'(mem[32'h31]), 64'h01);
    check("rsplit_byte1_unwritten", 64'(mem[32'h32]), 64'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
